// File: rtl/gmii_mac_tx.sv
`default_nettype none
// ============================================================================
// gmii_mac_tx : GMII MAC transmitter - preamble/SFD, payload, pad, FCS, IPG
// Revision    : 1.0
// ============================================================================
module gmii_mac_tx #(
    parameter int MIN_PAYLOAD  = 60,
    parameter int IPG_LEN      = 12,
    parameter int PREAMBLE_LEN = 7
) (
    input  logic        GTX_CLK,
    input  logic        mr_main_reset,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [7:0]  TXD,
    output logic        TX_EN,
    output logic        TX_ER,
    output logic        tx_busy,
    output logic [15:0] frames_sent
);
    localparam logic [15:0] C_IPG      = 16'(IPG_LEN);
    localparam logic [15:0] C_PRE      = 16'(PREAMBLE_LEN);
    localparam logic [31:0] C_CRC_INIT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREAMBLE = 3'd1,
        DATA     = 3'd2,
        DRAIN    = 3'd3,
        PAD      = 3'd4,
        FCS      = 3'd5,
        IPG      = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  txd_q, txd_d;
    logic        en_q, en_d;
    logic        er_q, er_d;
    logic [31:0] crc_q, crc_d;
    logic [10:0] cnt_q, cnt_d;
    logic [15:0] ctr_q, ctr_d;
    logic [15:0] frames_q, frames_d;

    function automatic logic [31:0] crc_upd(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c[0] ^ b[i]) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    logic [10:0] w_cnt_inc;
    logic        w_short;
    logic [31:0] w_fcs_sh;

    assign w_cnt_inc = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
    // True while the byte being emitted still leaves the frame below minimum.
    assign w_short   = (int'(cnt_q) + 1) < MIN_PAYLOAD;
    assign w_fcs_sh  = (~crc_q) >> {ctr_q[1:0], 3'b000};

    always_comb begin
        state_d  = state_q;
        txd_d    = 8'h00;
        en_d     = 1'b0;
        er_d     = 1'b0;
        crc_d    = crc_q;
        cnt_d    = cnt_q;
        ctr_d    = ctr_q;
        frames_d = frames_q;
        case (state_q)
            IDLE: begin
                if (s_valid) begin
                    state_d = PREAMBLE;
                    txd_d   = 8'h55;
                    en_d    = 1'b1;
                    ctr_d   = 16'd1;
                    crc_d   = C_CRC_INIT;
                    cnt_d   = 11'd0;
                end
            end
            PREAMBLE: begin
                en_d  = 1'b1;
                ctr_d = ctr_q + 16'd1;
                if (ctr_q >= C_PRE) begin
                    txd_d   = 8'hD5;
                    state_d = DATA;
                end else begin
                    txd_d = 8'h55;
                end
            end
            DATA: begin
                en_d = 1'b1;
                if (s_valid) begin
                    txd_d = s_data;
                    crc_d = crc_upd(crc_q, s_data);
                    cnt_d = w_cnt_inc;
                    if (s_last) begin
                        ctr_d   = 16'd0;
                        state_d = w_short ? PAD : FCS;
                    end
                end else begin
                    er_d    = 1'b1;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Starting at 1: TX_EN is already low, so the gap needs no extra cycle.
                if (s_valid && s_last) begin
                    state_d = IPG;
                    ctr_d   = 16'd1;
                end
            end
            PAD: begin
                en_d  = 1'b1;
                crc_d = crc_upd(crc_q, 8'h00);
                cnt_d = w_cnt_inc;
                if (!w_short) begin
                    state_d = FCS;
                    ctr_d   = 16'd0;
                end
            end
            FCS: begin
                en_d  = 1'b1;
                txd_d = w_fcs_sh[7:0];
                ctr_d = ctr_q + 16'd1;
                if (ctr_q[1:0] == 2'd3) begin
                    state_d  = IPG;
                    ctr_d    = 16'd0;
                    frames_d = frames_q + 16'd1;
                end
            end
            IPG: begin
                ctr_d = ctr_q + 16'd1;
                if (ctr_q >= C_IPG) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge GTX_CLK) begin
        if (mr_main_reset) begin
            state_q  <= IDLE;
            txd_q    <= 8'h00;
            en_q     <= 1'b0;
            er_q     <= 1'b0;
            crc_q    <= C_CRC_INIT;
            cnt_q    <= 11'd0;
            ctr_q    <= 16'd0;
            frames_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            txd_q    <= txd_d;
            en_q     <= en_d;
            er_q     <= er_d;
            crc_q    <= crc_d;
            cnt_q    <= cnt_d;
            ctr_q    <= ctr_d;
            frames_q <= frames_d;
        end
    end

    assign s_ready     = (state_q == DATA) || (state_q == DRAIN);
    assign tx_busy     = (state_q != IDLE);
    assign TXD         = txd_q;
    assign TX_EN       = en_q;
    assign TX_ER       = er_q;
    assign frames_sent = frames_q;

endmodule
`default_nettype wire

// File: tb/tb_gmii_mac_tx.sv
`default_nettype none
// ============================================================================
// tb_gmii_mac_tx : randomized frame bench with a queue-based frame model
// Revision       : 1.0
// ============================================================================
module tb_gmii_mac_tx;
    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_data;
    logic        s_valid, s_last;
    logic        r0_ready, r0_en, r0_er, r0_busy;
    logic [7:0]  r0_txd;
    logic [15:0] r0_frames;
    logic        r1_ready, r1_en, r1_er, r1_busy;
    logic [7:0]  r1_txd;
    logic [15:0] r1_frames;
    logic        sel = 1'b1;
    logic        w_ready, w_en, w_er, w_busy;
    logic [7:0]  w_txd;

    always #5 clk = ~clk;

    gmii_mac_tx #(.MIN_PAYLOAD(0)) u0 (
        .GTX_CLK(clk), .mr_main_reset(rst), .s_data(s_data), .s_valid(s_valid),
        .s_last(s_last), .s_ready(r0_ready), .TXD(r0_txd), .TX_EN(r0_en),
        .TX_ER(r0_er), .tx_busy(r0_busy), .frames_sent(r0_frames));

    gmii_mac_tx u1 (
        .GTX_CLK(clk), .mr_main_reset(rst), .s_data(s_data), .s_valid(s_valid),
        .s_last(s_last), .s_ready(r1_ready), .TXD(r1_txd), .TX_EN(r1_en),
        .TX_ER(r1_er), .tx_busy(r1_busy), .frames_sent(r1_frames));

    assign w_ready = sel ? r1_ready : r0_ready;
    assign w_en    = sel ? r1_en    : r0_en;
    assign w_er    = sel ? r1_er    : r0_er;
    assign w_busy  = sel ? r1_busy  : r0_busy;
    assign w_txd   = sel ? r1_txd   : r0_txd;

    int   n_checks = 0, n_pass = 0;
    bq_t  cap;
    int   en_cycles, er_cnt, er_idx, ready_gap;
    int   cyc = 0;
    int   rise_q[$], fall_q[$];
    logic prev_en = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (w_en) begin
            cap.push_back(w_txd);
            en_cycles++;
        end
        if (w_er) begin
            er_cnt++;
            er_idx = cap.size() - 1;
        end
        if (w_en && !prev_en) rise_q.push_back(cyc);
        if (!w_en && prev_en) fall_q.push_back(cyc);
        if (!w_en && w_ready && fall_q.size() > 0) ready_gap++;
        prev_en = w_en;
    end

    function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in;
        for (int k = 0; k < 8; k++) begin
            if (c[0] ^ b[k]) c = (c >> 1) ^ 32'hEDB8_8320;
            else             c = c >> 1;
        end
        return c;
    endfunction

    // Expected TXD stream (TX_EN-high bytes) for one complete frame.
    function automatic bq_t model(input bq_t p, input int minp);
        bq_t         e;
        logic [31:0] c;
        logic [7:0]  b;
        e = {};
        for (int i = 0; i < 7; i++) e.push_back(8'h55);
        e.push_back(8'hD5);
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < p.size() || i < minp; i++) begin
            b = (i < p.size()) ? p[i] : 8'h00;
            e.push_back(b);
            c = crc_step(c, b);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) e.push_back(c[8*k +: 8]);
        return e;
    endfunction

    function automatic int first_diff(input bq_t a, input bq_t b);
        for (int i = 0; i < a.size() && i < b.size(); i++)
            if (a[i] !== b[i]) return i;
        if (a.size() != b.size()) return (a.size() < b.size()) ? a.size() : b.size();
        return -1;
    endfunction

    function automatic bq_t rand_payload(input int n);
        bq_t p;
        p = {};
        for (int i = 0; i < n; i++) p.push_back(8'($urandom_range(0, 255)));
        return p;
    endfunction

    task automatic clear_mon();
        cap = {}; en_cycles = 0; er_cnt = 0; er_idx = -1; ready_gap = 0;
        rise_q = {}; fall_q = {};
    endtask

    task automatic do_reset();
        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send(input bq_t p, input int stall_at, input bit hold, output int acc);
        int   i = 0, guard = 0;
        bit   stalled = 1'b0;
        logic rdy;
        acc = 0;
        while (i < p.size() && guard < 3000) begin
            guard++;
            if (i == stall_at && !stalled) begin
                s_valid = 1'b0; s_last = 1'b0; stalled = 1'b1;
                @(posedge clk); #1;
            end else begin
                s_valid = 1'b1; s_data = p[i]; s_last = (i == p.size() - 1);
                rdy = w_ready;
                @(posedge clk); #1;
                if (rdy) begin i++; acc++; end
            end
        end
        if (!hold) begin s_valid = 1'b0; s_last = 1'b0; end
        if (i < p.size()) begin
            n_checks++;
            $display("FAIL send_timeout: accepted %0d of %0d bytes", i, p.size());
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (w_busy && k < 2000) begin @(posedge clk); #1; k++; end
        if (w_busy) begin
            n_checks++;
            $display("FAIL wait_idle: tx_busy still high after %0d cycles", k);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (r1_txd !== 8'h00)     $display("FAIL reset_txd: got %h want 00", r1_txd); else n_pass++;
        n_checks++; if (r1_en !== 1'b0)       $display("FAIL reset_en: got %b want 0", r1_en); else n_pass++;
        n_checks++; if (r1_er !== 1'b0)       $display("FAIL reset_er: got %b want 0", r1_er); else n_pass++;
        n_checks++; if (r1_ready !== 1'b0)    $display("FAIL reset_ready: got %b want 0", r1_ready); else n_pass++;
        n_checks++; if (r1_busy !== 1'b0)     $display("FAIL reset_busy: got %b want 0", r1_busy); else n_pass++;
        n_checks++; if (r1_frames !== 16'h0)  $display("FAIL reset_frames: got %h want 0000", r1_frames); else n_pass++;
        n_checks++; if (r0_en !== 1'b0)       $display("FAIL reset_en_u0: got %b want 0", r0_en); else n_pass++;
    endtask

    task automatic test_crc_vector();
        bq_t p, e; int acc, d, n; logic [31:0] got;
        sel = 1'b0; do_reset(); clear_mon();
        p = {};
        for (int i = 0; i < 9; i++) p.push_back(8'h31 + 8'(i));
        send(p, -1, 1'b0, acc); wait_idle();
        e = model(p, 0); d = first_diff(cap, e);
        n_checks++; if (d != -1) $display("FAIL crc_frame: got %0d bytes, want %0d, first diff at %0d", cap.size(), e.size(), d); else n_pass++;
        n = cap.size();
        got = (n >= 4) ? {cap[n-1], cap[n-2], cap[n-3], cap[n-4]} : 32'h0;
        n_checks++; if (got !== 32'hCBF4_3926) $display("FAIL crc_fcs: got %h want cbf43926", got); else n_pass++;
        n_checks++; if (en_cycles != 21) $display("FAIL crc_en_cycles: got %0d want 21", en_cycles); else n_pass++;
        n_checks++; if (r0_frames !== 16'd1) $display("FAIL crc_frames: got %0d want 1", r0_frames); else n_pass++;
    endtask

    task automatic test_pad();
        bq_t p, e; int acc, d;
        sel = 1'b1; do_reset(); clear_mon();
        p = {8'hAB};
        send(p, -1, 1'b0, acc); wait_idle();
        e = model(p, 60); d = first_diff(cap, e);
        n_checks++; if (d != -1) $display("FAIL pad_frame: got %0d bytes, want %0d, first diff at %0d", cap.size(), e.size(), d); else n_pass++;
        n_checks++; if (en_cycles != 72) $display("FAIL pad_en_cycles: got %0d want 72", en_cycles); else n_pass++;
        n_checks++; if (acc != 1) $display("FAIL pad_accepted: got %0d want 1", acc); else n_pass++;
        n_checks++; if (r1_frames !== 16'd1) $display("FAIL pad_frames: got %0d want 1", r1_frames); else n_pass++;
    endtask

    task automatic test_random_frames();
        bq_t p, e; int acc, d;
        int lens[6];
        lens = '{59, 60, 61, 0, 0, 0};
        for (int k = 3; k < 6; k++) lens[k] = int'($urandom_range(1, 120));
        sel = 1'b1; do_reset();
        for (int k = 0; k < 6; k++) begin
            clear_mon();
            p = rand_payload(lens[k]);
            send(p, -1, 1'b0, acc); wait_idle();
            e = model(p, 60); d = first_diff(cap, e);
            n_checks++; if (d != -1) $display("FAIL rand_frame len=%0d: got %0d bytes, want %0d, first diff at %0d", lens[k], cap.size(), e.size(), d); else n_pass++;
        end
        n_checks++; if (r1_frames !== 16'd6) $display("FAIL rand_frames_sent: got %0d want 6", r1_frames); else n_pass++;
    endtask

    task automatic test_back_to_back();
        bq_t p1, p2, e, e2; int acc, d, gap;
        sel = 1'b1; do_reset(); clear_mon();
        p1 = rand_payload(20); p2 = rand_payload(70);
        send(p1, -1, 1'b1, acc);
        send(p2, -1, 1'b0, acc);
        wait_idle();
        e = model(p1, 60); e2 = model(p2, 60);
        foreach (e2[i]) e.push_back(e2[i]);
        d = first_diff(cap, e);
        n_checks++; if (d != -1) $display("FAIL b2b_frames: got %0d bytes, want %0d, first diff at %0d", cap.size(), e.size(), d); else n_pass++;
        gap = (rise_q.size() >= 2 && fall_q.size() >= 1) ? rise_q[1] - fall_q[0] : -1;
        n_checks++; if (gap != 13) $display("FAIL b2b_gap: got %0d want 13", gap); else n_pass++;
        n_checks++; if (ready_gap != 0) $display("FAIL b2b_ready_in_ipg: got %0d cycles want 0", ready_gap); else n_pass++;
        n_checks++; if (r1_frames !== 16'd2) $display("FAIL b2b_frames_sent: got %0d want 2", r1_frames); else n_pass++;
    endtask

    task automatic test_underrun();
        bq_t p, e; int acc, d, k;
        sel = 1'b1; do_reset(); clear_mon();
        p = rand_payload(10);
        send(p, 5, 1'b0, acc);
        k = 0;
        while (w_busy && k < 100) begin k++; @(posedge clk); #1; end
        e = {};
        for (int i = 0; i < 7; i++) e.push_back(8'h55);
        e.push_back(8'hD5);
        for (int i = 0; i < 5; i++) e.push_back(p[i]);
        e.push_back(8'h00);
        d = first_diff(cap, e);
        n_checks++; if (d != -1) $display("FAIL underrun_frame: got %0d bytes, want %0d, first diff at %0d", cap.size(), e.size(), d); else n_pass++;
        n_checks++; if (er_cnt != 1 || er_idx != 13) $display("FAIL underrun_er: got %0d cycles at %0d want 1 at 13", er_cnt, er_idx); else n_pass++;
        n_checks++; if (r1_frames !== 16'd0) $display("FAIL underrun_frames: got %0d want 0", r1_frames); else n_pass++;
        n_checks++; if (k != 12) $display("FAIL underrun_ipg: got %0d busy cycles want 12", k); else n_pass++;
        n_checks++; if (acc != 10) $display("FAIL underrun_drained: got %0d want 10", acc); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bq_t p, e; int acc, d;
        sel = 1'b1; do_reset();
        p = rand_payload(10);
        send(p, -1, 1'b0, acc); wait_idle();
        s_valid = 1'b1; s_last = 1'b0;
        repeat (14) begin s_data = 8'($urandom_range(0, 255)); @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; s_valid = 1'b0;
        n_checks++; if (r1_en !== 1'b0) $display("FAIL midrst_en: got %b want 0", r1_en); else n_pass++;
        n_checks++; if (r1_ready !== 1'b0) $display("FAIL midrst_ready: got %b want 0", r1_ready); else n_pass++;
        n_checks++; if (r1_frames !== 16'd0) $display("FAIL midrst_frames: got %0d want 0", r1_frames); else n_pass++;
        n_checks++; if (r1_busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", r1_busy); else n_pass++;
        clear_mon();
        p = rand_payload(25);
        send(p, -1, 1'b0, acc); wait_idle();
        e = model(p, 60); d = first_diff(cap, e);
        n_checks++; if (d != -1) $display("FAIL midrst_frame: got %0d bytes, want %0d, first diff at %0d", cap.size(), e.size(), d); else n_pass++;
        n_checks++; if (r1_frames !== 16'd1) $display("FAIL midrst_frames_after: got %0d want 1", r1_frames); else n_pass++;
    endtask

    task automatic test_wrap();
        bq_t p; int acc;
        sel = 1'b1; do_reset();
        force u1.frames_q = 16'hFFFE;
        @(posedge clk); #1;
        release u1.frames_q;
        n_checks++; if (r1_frames !== 16'hFFFE) $display("FAIL wrap_preload: got %h want fffe", r1_frames); else n_pass++;
        p = rand_payload(1);
        send(p, -1, 1'b0, acc); wait_idle();
        n_checks++; if (r1_frames !== 16'hFFFF) $display("FAIL wrap_ffff: got %h want ffff", r1_frames); else n_pass++;
        send(p, -1, 1'b0, acc); wait_idle();
        n_checks++; if (r1_frames !== 16'h0000) $display("FAIL wrap_zero: got %h want 0000", r1_frames); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_crc_vector();
        test_pad();
        test_random_frames();
        test_back_to_back();
        test_underrun();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
